// File: rtl/reaction_game_fsm.sv
// rtl/reaction_game_fsm.sv - multi-round reaction-time game controller
//
// Purpose: runs a game of ROUNDS rounds. Each round waits a pseudo-random
// delay (MIN_DELAY_MS + LFSR bits) with the LED off, then lights the LED and
// measures the player's reaction in ms. A press during the delay is a false
// start and the round is retried. Best and total reaction times are kept per
// game.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   ms_tick        one-cycle strobe per millisecond
//   button_pressed synchronised button level
//   led_on         stimulus LED (high in WAIT)
//   result_valid   one-cycle pulse in the first SHOW cycle
//   reaction_ms    last recorded reaction time
//   false_start    high while in FALSE
//   best_ms        minimum reaction this game
//   total_ms       sum of recorded reactions this game
//   round_idx      completed rounds this game
//   done           high while in DONE
module reaction_game_fsm #(
  parameter int MAX_MS       = 2047,
  parameter int ROUNDS       = 5,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 10,
  localparam int W           = $clog2(MAX_MS + 1),
  localparam int RW          = $clog2(ROUNDS + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ms_tick,
  input  logic            button_pressed,
  output logic            led_on,
  output logic            result_valid,
  output logic [W-1:0]    reaction_ms,
  output logic            false_start,
  output logic [W-1:0]    best_ms,
  output logic [W+RW-1:0] total_ms,
  output logic [RW-1:0]   round_idx,
  output logic            done
);

  // Delay counter holds at most MIN_DELAY_MS + 2^RAND_BITS - 1.
  localparam int DW = $clog2(MIN_DELAY_MS + (1 << RAND_BITS));

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    WAIT  = 3'd2,
    SHOW  = 3'd3,
    FALSE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        state;
  logic          button_q;
  logic [15:0]   lfsr;
  logic [DW-1:0] delay_cnt;
  logic [W-1:0]  rt_cnt;

  logic          btn_edge;
  logic          lfsr_fb;
  logic [DW-1:0] delay_seed;
  logic          rec_en;
  logic [W-1:0]  rec_val;

  assign btn_edge   = button_pressed & ~button_q;
  // Fibonacci taps 16,14,13,11 (bit 15 is tap 16)
  assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign delay_seed = DW'(MIN_DELAY_MS) + DW'(lfsr[RAND_BITS-1:0]);

  // A round ends on a press (the tick in the same cycle is not counted) or on
  // the tick that would push the counter past MAX_MS.
  assign rec_en  = (state == WAIT) &&
                   (btn_edge || (ms_tick && (rt_cnt == W'(MAX_MS))));
  assign rec_val = btn_edge ? rt_cnt : W'(MAX_MS);

  // Status outputs decode the state register so reset clears them at once.
  assign led_on      = (state == WAIT);
  assign false_start = (state == FALSE);
  assign done        = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      button_q     <= 1'b1;
      lfsr         <= 16'hACE1;
      delay_cnt    <= '0;
      rt_cnt       <= '0;
      reaction_ms  <= '0;
      result_valid <= 1'b0;
      best_ms      <= W'(MAX_MS);
      total_ms     <= '0;
      round_idx    <= '0;
    end else begin
      button_q     <= button_pressed;
      lfsr         <= {lfsr[14:0], lfsr_fb};
      result_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (btn_edge) begin
            state     <= DELAY;
            delay_cnt <= delay_seed;
            round_idx <= '0;
            total_ms  <= '0;
            best_ms   <= W'(MAX_MS);
          end
        end

        DELAY: begin
          if (btn_edge) begin
            state <= FALSE;
          end else if (ms_tick) begin
            if (delay_cnt == DW'(1)) begin
              state  <= WAIT;
              rt_cnt <= '0;
            end else begin
              delay_cnt <= delay_cnt - DW'(1);
            end
          end
        end

        WAIT: begin
          if (rec_en) begin
            state        <= SHOW;
            reaction_ms  <= rec_val;
            result_valid <= 1'b1;
            round_idx    <= round_idx + RW'(1);
            total_ms     <= total_ms + {{RW{1'b0}}, rec_val};
            if (rec_val < best_ms) begin
              best_ms <= rec_val;
            end
          end else if (ms_tick) begin
            // rec_en covers rt_cnt == MAX_MS, so this cannot overflow
            rt_cnt <= rt_cnt + W'(1);
          end
        end

        SHOW: begin
          if (btn_edge) begin
            if (round_idx == RW'(ROUNDS)) begin
              state <= DONE;
            end else begin
              state     <= DELAY;
              delay_cnt <= delay_seed;
            end
          end
        end

        FALSE: begin
          if (btn_edge) begin
            state     <= DELAY;
            delay_cnt <= delay_seed;
          end
        end

        DONE: begin
          if (btn_edge) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_game_fsm.sv
// tb/tb_reaction_game_fsm.sv - scoreboard bench for reaction_game_fsm
module tb_reaction_game_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ms_tick = 1'b0;
  logic       button_pressed = 1'b1;
  logic       led_on;
  logic       result_valid;
  logic [3:0] reaction_ms;
  logic       false_start;
  logic [3:0] best_ms;
  logic [5:0] total_ms;
  logic [1:0] round_idx;
  logic       done;

  reaction_game_fsm #(
    .MAX_MS(15),
    .ROUNDS(3),
    .MIN_DELAY_MS(2),
    .RAND_BITS(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ms_tick(ms_tick),
    .button_pressed(button_pressed),
    .led_on(led_on),
    .result_valid(result_valid),
    .reaction_ms(reaction_ms),
    .false_start(false_start),
    .best_ms(best_ms),
    .total_ms(total_ms),
    .round_idx(round_idx),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] b;
    logic [5:0] t;
    logic [1:0] n;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_best = 15;
  int   exp_total = 0;
  int   exp_round = 0;

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed ACE1
  logic [15:0] lfsr_m;
  always @(posedge clk or posedge reset) begin
    if (reset) lfsr_m <= 16'hACE1;
    else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per result_valid pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result: got pulse reaction_ms=%0d, expected no pulse", reaction_ms);
        end else begin
          e = sb_q.pop_front();
          chk("sb_reaction_ms", int'(reaction_ms), int'(e.r));
          chk("sb_best_ms", int'(best_ms), int'(e.b));
          chk("sb_total_ms", int'(total_ms), int'(e.t));
          chk("sb_round_idx", int'(round_idx), int'(e.n));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // One clock: drive inputs just after the rising edge, sample 1 ns later
  task automatic cyc(input logic b, input logic t);
    button_pressed = b;
    ms_tick = t;
    @(posedge clk);
    #1;
  endtask

  // n millisecond periods of 4 clocks each, the tick on the last clock
  task automatic run_ms(input int n, input logic b);
    for (int i = 0; i < n; i++) begin
      cyc(b, 1'b0);
      cyc(b, 1'b0);
      cyc(b, 1'b0);
      cyc(b, 1'b1);
    end
  endtask

  task automatic game_start_model();
    exp_best = 15;
    exp_total = 0;
    exp_round = 0;
  endtask

  task automatic expect_result(input int r);
    exp_t e;
    exp_round++;
    exp_total += r;
    if (r < exp_best) exp_best = r;
    e.r = 4'(r);
    e.b = 4'(exp_best);
    e.t = 6'(exp_total);
    e.n = 2'(exp_round);
    sb_q.push_back(e);
  endtask

  // Press into DELAY; returns the delay the DUT should load
  task automatic go_delay(output int d);
    d = 2 + int'(lfsr_m[1:0]);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
  endtask

  task automatic wait_led(input int d);
    run_ms(d - 1, 1'b0);
    chk("led_before_expiry", int'(led_on), 0);
    run_ms(1, 1'b0);
    chk("led_after_delay", int'(led_on), 1);
  endtask

  task automatic start_round();
    int d;
    go_delay(d);
    wait_led(d);
  endtask

  // Respond after n ticks; optionally on the same cycle as a WAIT tick
  task automatic respond(input int n, input bit coincide);
    run_ms(n, 1'b0);
    expect_result(n);
    if (coincide) begin
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b1);
    end else begin
      cyc(1'b1, 1'b0);
    end
    chk("led_off_in_show", int'(led_on), 0);
    cyc(1'b0, 1'b0);
  endtask

  task automatic timeout_round();
    run_ms(15, 1'b0);
    chk("led_at_rt_max", int'(led_on), 1);
    expect_result(15);
    run_ms(1, 1'b0);
    chk("led_off_after_timeout", int'(led_on), 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_led_on"}, int'(led_on), 0);
    chk({tag, "_result_valid"}, int'(result_valid), 0);
    chk({tag, "_reaction_ms"}, int'(reaction_ms), 0);
    chk({tag, "_false_start"}, int'(false_start), 0);
    chk({tag, "_best_ms"}, int'(best_ms), 15);
    chk({tag, "_total_ms"}, int'(total_ms), 0);
    chk({tag, "_round_idx"}, int'(round_idx), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    int d;

    // 1: reset with button held, no edge from the held level
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    reset = 1'b0;
    run_ms(6, 1'b1);
    chk("held_no_start_led", int'(led_on), 0);
    chk("held_no_start_false", int'(false_start), 0);
    cyc(1'b0, 1'b0);

    // 2: full game, reactions 3, 5, 4
    game_start_model();
    start_round();
    respond(3, 1'b0);
    start_round();
    respond(5, 1'b0);
    start_round();
    respond(4, 1'b0);
    chk("g1_done_before_press", int'(done), 0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("g1_done", int'(done), 1);
    chk("g1_best", int'(best_ms), 3);
    chk("g1_total", int'(total_ms), 12);
    chk("g1_rounds", int'(round_idx), 3);
    run_ms(2, 1'b0);
    chk("g1_done_held", int'(done), 1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("g1_idle_done_low", int'(done), 0);
    chk("g1_idle_best_kept", int'(best_ms), 3);

    // 3: false start during DELAY, then retry
    game_start_model();
    go_delay(d);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("fs_flag", int'(false_start), 1);
    chk("fs_round", int'(round_idx), 0);
    run_ms(6, 1'b0);
    chk("fs_led_off", int'(led_on), 0);
    chk("fs_flag_held", int'(false_start), 1);
    start_round();
    chk("fs_cleared", int'(false_start), 0);
    respond(2, 1'b0);

    // 5a: edge on the delay-expiring tick -> FALSE
    go_delay(d);
    run_ms(d - 1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    chk("coinc_false", int'(false_start), 1);
    chk("coinc_led", int'(led_on), 0);
    cyc(1'b0, 1'b0);
    // 5b: edge on a WAIT tick with rt_cnt=6 -> 6
    start_round();
    respond(6, 1'b1);

    // 4: timeout as a later round, best stays 2
    start_round();
    timeout_round();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("g2_done", int'(done), 1);
    chk("g2_total", int'(total_ms), 23);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);

    // 4: timeout as first round -> best 15
    game_start_model();
    start_round();
    timeout_round();
    chk("to_first_best", int'(best_ms), 15);

    // 6: reset asserted mid-WAIT
    start_round();
    run_ms(2, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("midrst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1'b0, 1'b0);
    chk("post_rst_led", int'(led_on), 0);

    repeat (4) cyc(1'b0, 1'b0);
    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
